// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register ready countdowns beside ID, ID stall
// generation and sequencing of the single shared iterative divider.
// Optional performance counters are built when SCOREBOARD_PERF_EN is defined.
module issue_scoreboard #(
  parameter int CNT_W    = 3,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 3,
  parameter int NREG     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_stall,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_rf_we,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      id_class,
  input  logic            div_done,
  output logic            id_ready,
  output logic            stallreq_id,
  output logic            issue_fire,
  output logic            div_busy,
`ifdef SCOREBOARD_PERF_EN
  output logic [31:0]     perf_raw_stall,
  output logic [31:0]     perf_div_stall,
  output logic [31:0]     perf_issue,
`endif
  output logic [NREG-1:0] pend_vec
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} div_state_e;

  localparam logic [1:0]       CLS_ALU  = 2'd0;
  localparam logic [1:0]       CLS_LOAD = 2'd1;
  localparam logic [1:0]       CLS_MUL  = 2'd2;
  localparam logic [1:0]       CLS_DIV  = 2'd3;
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_INIT  = CNT_W'(MUL_LAT - 1);

  logic [NREG-1:0][CNT_W-1:0] r_cnt;
  div_state_e                 r_state, w_state_nxt;
  logic [4:0]                 r_div_rd, w_div_rd_nxt;

  logic w_busy, w_raw1, w_raw2, w_struct, w_waw, w_raw, w_divh;
  logic w_wr_issue, w_div_issue;

  assign w_busy = (r_state == S_BUSY);

  // Pending: countdown still running, or the outstanding divide's destination.
  always_comb begin
    pend_vec = '0;
    for (int i = 1; i < NREG; i++)
      pend_vec[i] = (r_cnt[i] != '0) | (w_busy & (r_div_rd == 5'(i)));
  end

  // Hazard detection; a countdown reaching zero this cycle still blocks.
  assign w_raw1   = id_use_rs1 & (id_rs1 != 5'd0) & pend_vec[id_rs1];
  assign w_raw2   = id_use_rs2 & (id_rs2 != 5'd0) & pend_vec[id_rs2];
  assign w_struct = (id_class == CLS_DIV) & w_busy & ~div_done;
  assign w_waw    = id_rf_we & (id_rd != 5'd0) & w_busy & (id_rd == r_div_rd);
  assign w_raw    = w_raw1 | w_raw2;
  assign w_divh   = w_struct | w_waw;

  assign id_ready    = ~(w_raw | w_divh);
  assign stallreq_id = id_valid & ~id_ready;
  assign issue_fire  = id_valid & id_ready & ~ex_stall & ~flush;
  assign div_busy    = w_busy;

  assign w_wr_issue  = issue_fire & id_rf_we & (id_rd != 5'd0);
  assign w_div_issue = issue_fire & (id_class == CLS_DIV);

  // Per-register countdown: flush clears, issue loads, otherwise decrement unless stalled.
  always_ff @(posedge clk) begin
    r_cnt[0] <= '0;
    for (int i = 1; i < NREG; i++) begin
      if (!rst_n || flush)
        r_cnt[i] <= '0;
      else if (w_wr_issue && (id_rd == 5'(i))) begin
        case (id_class)
          CLS_LOAD: r_cnt[i] <= LOAD_INIT;
          CLS_MUL:  r_cnt[i] <= MUL_INIT;
          default:  r_cnt[i] <= '0;
        endcase
      end else if (!ex_stall && (r_cnt[i] != '0))
        r_cnt[i] <= r_cnt[i] - 1'b1;
    end
  end

  // Divider FSM state and destination register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_div_rd <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div_rd <= w_div_rd_nxt;
    end
  end

  // Divider next state: a new divide wins over a same-cycle completion.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_rd_nxt = r_div_rd;
    if (flush) begin
      w_state_nxt  = S_IDLE;
      w_div_rd_nxt = '0;
    end else if (w_div_issue) begin
      w_state_nxt  = S_BUSY;
      w_div_rd_nxt = (id_rf_we && id_rd != 5'd0) ? id_rd : 5'd0;
    end else if (w_busy && div_done) begin
      w_state_nxt  = S_IDLE;
      w_div_rd_nxt = '0;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] r_perf_raw, r_perf_div, r_perf_iss;

  // Saturating event counters; survive flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_raw <= '0;
      r_perf_div <= '0;
      r_perf_iss <= '0;
    end else begin
      if (id_valid && w_raw && r_perf_raw != 32'hFFFF_FFFF) r_perf_raw <= r_perf_raw + 1'b1;
      if (id_valid && w_divh && r_perf_div != 32'hFFFF_FFFF) r_perf_div <= r_perf_div + 1'b1;
      if (issue_fire && r_perf_iss != 32'hFFFF_FFFF) r_perf_iss <= r_perf_iss + 1'b1;
    end
  end

  assign perf_raw_stall = r_perf_raw;
  assign perf_div_stall = r_perf_div;
  assign perf_issue     = r_perf_iss;
`endif

endmodule
